// File: rtl/demultiplexor6_tdm_if.sv
// Bus bundle for the 64-slot TDM demultiplexer: serial input side, parallel output side,
// slot index, framing error and the output state for debug.
interface demultiplexor6_tdm_if #(
  parameter int WIDTH = 64,
  parameter int SEL_W = 6
);
  // Handshakes: a transfer happens on a posedge where valid & ready are both high. The
  // producer holds its payload steady while valid & !ready; ready never waits on a later valid.
  logic             in_bit;
  logic             in_valid;
  logic             in_sync;
  logic             in_ready;
  logic [WIDTH-1:0] out_word;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] slot;
  logic             frame_err;
  logic             out_state;

  modport master (
    output in_bit, in_valid, in_sync, out_ready,
    input  in_ready, out_word, out_valid, slot, frame_err, out_state
  );

  modport slave (
    input  in_bit, in_valid, in_sync, out_ready,
    output in_ready, out_word, out_valid, slot, frame_err, out_state
  );
endinterface

// File: rtl/demultiplexor6_tdm.sv
// Receive end of a 64:1 TDM link: one serial bit per slot is assembled into a parallel word
// and offered on a valid/ready output with a one-word holding register.
module demultiplexor6_tdm #(
  parameter int WIDTH = 64,
  parameter int SEL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  demultiplexor6_tdm_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  out_state_t       state, state_nx;
  logic [WIDTH-2:0] asm_buf;
  logic [WIDTH-1:0] out_word_q;
  logic [SEL_W-1:0] slot_q;
  logic [SEL_W-1:0] wr_slot;
  logic             last;
  logic             accept;
  logic             complete;
  logic             frame_err_q;

  // A sync marker forces the write to slot 0 regardless of where the counter stands.
  assign wr_slot  = bus.in_sync ? '0 : slot_q;
  assign last     = (wr_slot == SEL_W'(WIDTH - 1));
  assign bus.in_ready = !(last && (state == FULL) && !bus.out_ready);
  assign accept   = bus.in_valid && bus.in_ready;
  assign complete = accept && last;

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (complete) state_nx = FULL;
      FULL:  if (bus.out_ready && !complete) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      slot_q      <= '0;
      asm_buf     <= '0;
      out_word_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_nx;
      frame_err_q <= accept && bus.in_sync && (slot_q != '0);
      if (accept) begin
        if (wr_slot == '0) begin
          // Start of frame wipes the buffer so an abandoned frame cannot leak into this one.
          asm_buf <= {{(WIDTH - 2){1'b0}}, bus.in_bit};
        end else if (!last) begin
          asm_buf[wr_slot] <= bus.in_bit;
        end
        if (last) begin
          out_word_q <= {bus.in_bit, asm_buf};
          slot_q     <= '0;
        end else begin
          slot_q     <= wr_slot + SEL_W'(1);
        end
      end
    end
  end

  assign bus.out_word  = out_word_q;
  assign bus.out_valid = (state == FULL);
  assign bus.slot      = slot_q;
  assign bus.frame_err = frame_err_q;
  assign bus.out_state = logic'(state);

endmodule
